// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment receive path.
// Patterns are active-low with bit0 = segment a ... bit6 = segment g.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg7_pattern_to_bcd.sv
// Inverse segment map: active-low 7-bit pattern to BCD value with blank/illegal flags.
module seg7_pattern_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       is_blank,
  output logic       is_err
);

  always_comb begin
    value    = 4'hF;
    is_blank = 1'b0;
    is_err   = 1'b0;
    case (pattern)
      SEG_0:     value = 4'd0;
      SEG_1:     value = 4'd1;
      SEG_2:     value = 4'd2;
      SEG_3:     value = 4'd3;
      SEG_4:     value = 4'd4;
      SEG_5:     value = 4'd5;
      SEG_6:     value = 4'd6;
      SEG_7:     value = 4'd7;
      SEG_8:     value = 4'd8;
      SEG_9:     value = 4'd9;
      SEG_BLANK: begin
        value    = 4'd0;
        is_blank = 1'b1;
      end
      default:   is_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed active-low segment/anode bus, filters each digit for
// stability and assembles the recovered BCD digits into frames.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned STABLE_CYC = 16,
  parameter int unsigned CNT_W      = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [N_DIGITS-1:0]     an,
  output logic [4*N_DIGITS-1:0]   digits,
  output logic [N_DIGITS-1:0]     blank,
  output logic [N_DIGITS-1:0]     err,
  output logic                    frame_valid
);

  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned ZC_W  = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);

  logic [6:0]            seg_m_q, seg_s_q;
  logic [N_DIGITS-1:0]   an_m_q, an_s_q;
  scan_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [N_DIGITS-1:0]   ref_an_q, ref_an_d;
  logic [6:0]            ref_seg_q, ref_seg_d;
  logic [N_DIGITS-1:0]   seen_q, seen_d;
  logic [4*N_DIGITS-1:0] digits_q, digits_d;
  logic [N_DIGITS-1:0]   blank_q, blank_d;
  logic [N_DIGITS-1:0]   err_q, err_d;
  logic                  frame_valid_q, frame_valid_d;

  logic [ZC_W-1:0]       zero_cnt;
  logic [IDX_W-1:0]      an_idx;
  logic                  an_legal;
  logic                  same;
  logic [N_DIGITS-1:0]   seen_set;
  logic [3:0]            dec_value;
  logic                  dec_blank, dec_err;

  seg7_pattern_to_bcd u_dec (
    .pattern  (ref_seg_q),
    .value    (dec_value),
    .is_blank (dec_blank),
    .is_err   (dec_err)
  );

  // Exactly one low anode is legal; its position selects the digit.
  always_comb begin
    zero_cnt = '0;
    an_idx   = '0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (!an_s_q[i]) begin
        zero_cnt = zero_cnt + ZC_W'(1);
        an_idx   = IDX_W'(i);
      end
    end
  end

  assign an_legal = (zero_cnt == ZC_W'(1));
  assign same     = (an_s_q == ref_an_q) && (seg_s_q == ref_seg_q);
  assign seen_set = seen_q | (N_DIGITS'(1) << an_idx);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ref_an_d      = ref_an_q;
    ref_seg_d     = ref_seg_q;
    seen_d        = seen_q;
    digits_d      = digits_q;
    blank_d       = blank_q;
    err_d         = err_q;
    frame_valid_d = 1'b0;

    if (!an_legal) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        SETTLE: begin
          if (!same) begin
            cnt_d     = '0;
            ref_an_d  = an_s_q;
            ref_seg_d = seg_s_q;
          end else if (cnt_q == CNT_MAX) begin
            // Stable long enough: commit the digit and update the frame mask.
            state_d                       = HELD;
            digits_d[{an_idx, 2'b00} +: 4] = dec_value;
            blank_d[an_idx]               = dec_blank;
            err_d[an_idx]                 = dec_err;
            if (&seen_set) begin
              frame_valid_d = 1'b1;
              seen_d        = '0;
            end else begin
              seen_d = seen_set;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          if (!same) begin
            state_d   = SETTLE;
            cnt_d     = '0;
            ref_an_d  = an_s_q;
            ref_seg_d = seg_s_q;
          end
        end
        default: begin
          state_d   = SETTLE;
          cnt_d     = '0;
          ref_an_d  = an_s_q;
          ref_seg_d = seg_s_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_m_q       <= '1;
      seg_s_q       <= '1;
      an_m_q        <= '1;
      an_s_q        <= '1;
      state_q       <= IDLE;
      cnt_q         <= '0;
      ref_an_q      <= '1;
      ref_seg_q     <= '1;
      seen_q        <= '0;
      digits_q      <= '0;
      blank_q       <= '1;
      err_q         <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      seg_m_q       <= seg;
      seg_s_q       <= seg_m_q;
      an_m_q        <= an;
      an_s_q        <= an_m_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ref_an_q      <= ref_an_d;
      ref_seg_q     <= ref_seg_d;
      seen_q        <= seen_d;
      digits_q      <= digits_d;
      blank_q       <= blank_d;
      err_q         <= err_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign digits      = digits_q;
  assign blank       = blank_q;
  assign err         = err_q;
  assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with N_DIGITS=4, STABLE_CYC=16.
module tb_seg7_scan_decoder;
  import seg7_pkg::*;

  logic        clk;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic [3:0]  err;
  logic        frame_valid;

  logic [6:0]  pat;
  logic [3:0]  pat_value;
  logic        pat_blank, pat_err;

  int          n_checks;
  int          n_errors;
  int          fv_cnt;
  logic [15:0] fv_digits;

  seg7_scan_decoder #(
    .N_DIGITS   (4),
    .STABLE_CYC (16),
    .CNT_W      (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .an          (an),
    .digits      (digits),
    .blank       (blank),
    .err         (err),
    .frame_valid (frame_valid)
  );

  seg7_pattern_to_bcd u_ref_dec (
    .pattern  (pat),
    .value    (pat_value),
    .is_blank (pat_blank),
    .is_err   (pat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cnt    = fv_cnt + 1;
      fv_digits = digits;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bus value at a negedge and hold it for n rising edges, then settle #1.
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    @(negedge clk);
    an  = a;
    seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    fv_cnt    = 0;
    fv_digits = '0;
    rst       = 1'b1;
    an        = 4'b1111;
    seg       = SEG_BLANK;
    pat       = SEG_BLANK;

    // Pattern decoder spot checks
    pat = SEG_9;     #1; check("dec9_val", 32'(pat_value), 32'h9); check("dec9_err", 32'(pat_err), 32'h0);
    pat = 7'b0110000; #1; check("dec3_val", 32'(pat_value), 32'h3);
    pat = 7'b1111111; #1; check("decblank", 32'({pat_value, pat_blank, pat_err}), 32'b0000_1_0);
    pat = 7'b0000001; #1; check("decill",   32'({pat_value, pat_blank, pat_err}), 32'b1111_0_1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_blank",  32'(blank),  32'hF);
    check("rst_err",    32'(err),    32'h0);
    check("rst_fv",     32'(frame_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single digit capture latency
    drive(4'b1110, SEG_2, 16);
    check("lat_early", 32'(digits), 32'h0);
    repeat (4) @(posedge clk);
    #1;
    check("lat_digit", 32'(digits), 32'h0002);
    check("lat_blank", 32'(blank),  32'hE);
    check("lat_err",   32'(err),    32'h0);
    check("lat_nofv",  32'(fv_cnt), 32'd0);

    // Full scan 1,9,0,7
    drive(4'b1110, SEG_1, 32);
    drive(4'b1101, SEG_9, 32);
    drive(4'b1011, SEG_0, 32);
    check("scan1_prefv", 32'(fv_cnt), 32'd0);
    drive(4'b0111, SEG_7, 32);
    check("scan1_fv",     32'(fv_cnt),    32'd1);
    check("scan1_fvdig",  32'(fv_digits), 32'h7091);
    check("scan1_digits", 32'(digits),    32'h7091);
    check("scan1_blank",  32'(blank),     32'h0);
    drive(4'b1110, SEG_1, 32);
    drive(4'b1101, SEG_9, 32);
    drive(4'b1011, SEG_0, 32);
    check("scan2_prefv", 32'(fv_cnt), 32'd1);
    drive(4'b0111, SEG_7, 32);
    check("scan2_fv", 32'(fv_cnt), 32'd2);

    // Blank and illegal patterns on digit 1
    drive(4'b1101, SEG_BLANK, 24);
    check("blk_digits", 32'(digits), 32'h7001);
    check("blk_blank",  32'(blank),  32'h2);
    check("blk_err",    32'(err),    32'h0);
    drive(4'b1101, 7'b0101010, 24);
    check("ill_digits", 32'(digits), 32'h70F1);
    check("ill_blank",  32'(blank),  32'h0);
    check("ill_err",    32'(err),    32'h2);

    // Glitch filtering on digit 0
    drive(4'b1110, SEG_8, 24);
    check("g_base", 32'(digits), 32'h70F8);
    drive(4'b1110, SEG_1, 5);
    drive(4'b1110, SEG_8, 30);
    check("g_short_dig", 32'(digits), 32'h70F8);
    check("g_short_err", 32'(err),    32'h2);
    drive(4'b1110, SEG_1, 24);
    check("g_long_dig", 32'(digits), 32'h70F1);

    // Illegal anodes: nothing captured
    drive(4'b1100, SEG_3, 50);
    check("two_an_dig", 32'(digits), 32'h70F1);
    drive(4'b1111, SEG_3, 50);
    check("no_an_dig", 32'(digits), 32'h70F1);
    check("no_an_blk", 32'({blank, err}), 32'h02);
    check("no_an_fv",  32'(fv_cnt), 32'd2);

    // Reset with a partial frame pending
    drive(4'b1110, SEG_3, 32);
    drive(4'b1101, SEG_4, 32);
    drive(4'b1011, SEG_5, 32);
    check("part_digits", 32'(digits), 32'h7543);
    check("part_fv",     32'(fv_cnt), 32'd2);
    drive(4'b0111, SEG_6, 10);
    @(negedge clk);
    rst = 1'b1;
    an  = 4'b1111;
    seg = SEG_BLANK;
    #1;
    check("mrst_digits", 32'(digits), 32'h0);
    check("mrst_blank",  32'(blank),  32'hF);
    check("mrst_err",    32'(err),    32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0111, SEG_6, 32);
    check("post_d3", 32'(digits), 32'h6000);
    check("post_nofv", 32'(fv_cnt), 32'd2);
    drive(4'b1110, SEG_3, 32);
    drive(4'b1101, SEG_4, 32);
    check("post_nofv2", 32'(fv_cnt), 32'd2);
    drive(4'b1011, SEG_5, 32);
    check("post_fv",    32'(fv_cnt),    32'd3);
    check("post_fvdig", 32'(fv_digits), 32'h6543);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
